// File: rtl/uart_tx_drain.sv
// UART transmit drain: fetches bytes from the buffer read port and shifts them out as 8N1 frames.
// Define UART_TX_PARITY_EN to append an even parity bit (8E1).
module uart_tx_drain #(
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   len_i,
  input  logic [15:0]             clks_per_bit_i,
  input  logic                    abort_i,
  input  logic                    buffer_empty_i,
  input  logic [BUFFER_WIDTH:0]   rdata_i,
  output logic                    re_o,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    drop_o,
  output logic [ADDR_WIDTH-1:0]   sent_o
);

  localparam int unsigned IDX_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    CAPTURE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    NEXT,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   remaining_q;
  logic [ADDR_WIDTH-1:0]   sent_q;
  logic [15:0]             period_q;
  logic [15:0]             baud_q;
  logic [BUFFER_WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0]        idx_q;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q;
`endif
  logic                    tx_q, busy_q, done_q, drop_q;
  logic                    bit_end, in_frame, line_d;

  assign bit_end = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    re_o    = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i && (len_i != '0)) state_d = FETCH;
        FETCH: begin
          if (buffer_empty_i) begin
            state_d = DONE;
          end else begin
            re_o    = 1'b1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: state_d = rdata_i[0] ? START : NEXT;
        START:   if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
        DATA:    if (bit_end && (idx_q == LAST_IDX)) state_d = PARITY;
        PARITY:  if (bit_end) state_d = STOP;
`else
        DATA:    if (bit_end && (idx_q == LAST_IDX)) state_d = STOP;
`endif
        STOP:    if (bit_end) state_d = NEXT;
        NEXT:    state_d = (remaining_q != '0) ? FETCH : DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    line_d   = 1'b1;
    in_frame = 1'b0;
    case (state_q)
      START: begin
        line_d   = 1'b0;
        in_frame = 1'b1;
      end
      DATA: begin
        line_d   = shreg_q[0];
        in_frame = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_d   = parity_q;
        in_frame = 1'b1;
      end
`endif
      STOP:    in_frame = 1'b1;
      default: begin
        line_d   = 1'b1;
        in_frame = 1'b0;
      end
    endcase
  end

  // tx is registered off the current state, so the line trails the FSM by one cycle
  // while every bit still lasts exactly one period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      sent_q      <= '0;
      period_q    <= '0;
      baud_q      <= '0;
      shreg_q     <= '0;
      idx_q       <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      tx_q    <= line_d;
      if (abort_i) begin
        tx_q   <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (len_i == '0) begin
                done_q <= 1'b1;
              end else begin
                remaining_q <= len_i;
                period_q    <= (clks_per_bit_i == '0) ? 16'd1 : clks_per_bit_i;
                sent_q      <= '0;
                busy_q      <= 1'b1;
              end
            end
          end
          CAPTURE: begin
            if (rdata_i[0]) begin
              shreg_q  <= rdata_i[BUFFER_WIDTH:1];
`ifdef UART_TX_PARITY_EN
              parity_q <= ^rdata_i[BUFFER_WIDTH:1];
`endif
              idx_q    <= '0;
              baud_q   <= period_q - 16'd1;
            end else begin
              drop_q      <= 1'b1;
              remaining_q <= remaining_q - 1'b1;
            end
          end
          DONE: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          default: ;
        endcase

        if (in_frame) begin
          if (bit_end) begin
            baud_q <= period_q - 16'd1;
            if (state_q == DATA) begin
              shreg_q <= shreg_q >> 1;
              idx_q   <= idx_q + 1'b1;
            end
            if (state_q == STOP) begin
              remaining_q <= remaining_q - 1'b1;
              if (sent_q != '1) sent_q <= sent_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
      end
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign drop_o = drop_q;
  assign sent_o = sent_q;

endmodule
